// File: rtl/hazard_stall_unit_pkg.sv
// Shared definitions for the decode-stage hazard detector (package cpu_pkg).
// Register-index width, scoreboard depth, scoreboard entry layout, FSM states
// and the source/destination compare helper.
package cpu_pkg;

    localparam int REG_BITS   = 4;
    localparam int PIPE_DEPTH = 3;
    localparam int HOLD_BITS  = $clog2(PIPE_DEPTH + 2);

    // One in-flight writer: valid, destination register, and whether it is a load.
    typedef struct packed {
        logic                v;
        logic [REG_BITS-1:0] rd;
        logic                load;
    } sb_entry_t;

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    // A live source collides with a valid in-flight destination.
    function automatic logic src_hit(input sb_entry_t e, input logic live,
                                     input logic [REG_BITS-1:0] src);
        return e.v & live & (e.rd == src);
    endfunction

endpackage

// File: rtl/hazard_stall_unit_if.sv
// Decode-side bundle of the hazard detector: decoded control fields in,
// stall/bubble/status out. The decoder side uses master, the unit uses slave.
interface hazard_stall_unit_if;
    import cpu_pkg::*;

    logic                valid;
    logic                write;
    logic [REG_BITS-1:0] writeReg;
    logic [REG_BITS-1:0] readReg0;
    logic [REG_BITS-1:0] readReg1;
    logic                immediate;
    logic                ReadMem;
    logic                flush;
    logic                stall;
    logic                bubble;
    logic [15:0]         stall_cycles;
    logic                err;

    modport master (
        output valid, write, writeReg, readReg0, readReg1, immediate, ReadMem, flush,
        input  stall, bubble, stall_cycles, err
    );

    modport slave (
        input  valid, write, writeReg, readReg0, readReg1, immediate, ReadMem, flush,
        output stall, bubble, stall_cycles, err
    );

endinterface

// File: rtl/hazard_stall_unit_scoreboard.sv
// hazard_scoreboard: shift register of in-flight destination registers and
// the per-entry match vector against the live decode sources.
// HAZARD_FORWARD_EN: when defined only a load in the youngest entry can match
// (the bypass network covers everything else).
module hazard_scoreboard
    import cpu_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_insert,
    input  logic [REG_BITS-1:0]   i_write_reg,
    input  logic                  i_load,
    input  logic                  i_live0,
    input  logic [REG_BITS-1:0]   i_read_reg0,
    input  logic                  i_live1,
    input  logic [REG_BITS-1:0]   i_read_reg1,
    output logic [PIPE_DEPTH-1:0] o_match
);

    sb_entry_t r_sb [PIPE_DEPTH];

    // Age every entry by one place each cycle; entry 0 takes the issuing writer or a hole.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < PIPE_DEPTH; i++) begin
                r_sb[i] <= '{v: 1'b0, rd: {REG_BITS{1'b0}}, load: 1'b0};
            end
        end else begin
            r_sb[0] <= '{v: i_insert, rd: i_write_reg, load: i_load};
            for (int i = 1; i < PIPE_DEPTH; i++) begin
                r_sb[i] <= r_sb[i-1];
            end
        end
    end

    // Flag every qualifying entry whose destination equals a live source.
    always_comb begin
        o_match = {PIPE_DEPTH{1'b0}};
        for (int i = 0; i < PIPE_DEPTH; i++) begin
`ifdef HAZARD_FORWARD_EN
            if (i == 0) begin
                o_match[i] = r_sb[i].load &
                             (src_hit(r_sb[i], i_live0, i_read_reg0) |
                              src_hit(r_sb[i], i_live1, i_read_reg1));
            end else begin
                o_match[i] = 1'b0;
            end
`else
            o_match[i] = src_hit(r_sb[i], i_live0, i_read_reg0) |
                         src_hit(r_sb[i], i_live1, i_read_reg1);
`endif
        end
    end

endmodule

// File: rtl/hazard_stall_unit.sv
// hazard_stall_unit: decode-stage stall/bubble generator with RUN/HOLD FSM,
// saturating stall-cycle counter and a sticky hold-length watchdog.
// HAZARD_FORWARD_EN selects load-use-only stalling (see hazard_scoreboard).
module hazard_stall_unit
    import cpu_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    hazard_stall_unit_if.slave  bus
);

    localparam logic [HOLD_BITS-1:0] HOLD_MAX = HOLD_BITS'(PIPE_DEPTH + 1);

    logic [PIPE_DEPTH-1:0] w_match;
    logic                  w_live0;
    logic                  w_live1;
    logic                  w_stall;
    logic                  w_insert;
    state_t                r_state;
    state_t                w_state_nxt;
    logic [HOLD_BITS-1:0]  r_hold_cnt;
    logic [15:0]           r_stall_cycles;
    logic                  r_err;

    assign w_live0  = bus.valid;
    assign w_live1  = bus.valid & ~bus.immediate;
    // flush beats a hazard: no stall and the killed instruction never enters the scoreboard
    assign w_stall  = (|w_match) & ~bus.flush;
    assign w_insert = bus.valid & bus.write & ~w_stall & ~bus.flush;

    hazard_scoreboard u_sb (
        .clk         (clk),
        .rst         (rst),
        .i_insert    (w_insert),
        .i_write_reg (bus.writeReg),
        .i_load      (bus.ReadMem),
        .i_live0     (w_live0),
        .i_read_reg0 (bus.readReg0),
        .i_live1     (w_live1),
        .i_read_reg1 (bus.readReg1),
        .o_match     (w_match)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state: HOLD while stalling, flush always returns to RUN.
    always_comb begin
        w_state_nxt = ST_RUN;
        case (r_state)
            ST_RUN: begin
                if (bus.flush)   w_state_nxt = ST_RUN;
                else if (w_stall) w_state_nxt = ST_HOLD;
                else             w_state_nxt = ST_RUN;
            end
            ST_HOLD: begin
                if (bus.flush)   w_state_nxt = ST_RUN;
                else if (w_stall) w_state_nxt = ST_HOLD;
                else             w_state_nxt = ST_RUN;
            end
            default: w_state_nxt = ST_RUN;
        endcase
    end

    // Consecutive-HOLD counter and sticky watchdog for a hold longer than the pipe can explain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hold_cnt <= {HOLD_BITS{1'b0}};
            r_err      <= 1'b0;
        end else begin
            if (w_state_nxt == ST_HOLD) begin
                if (r_hold_cnt != HOLD_MAX) r_hold_cnt <= r_hold_cnt + 1'b1;
                else                        r_hold_cnt <= r_hold_cnt;
            end else begin
                r_hold_cnt <= {HOLD_BITS{1'b0}};
            end
            if (r_hold_cnt == HOLD_MAX) r_err <= 1'b1;
            else                        r_err <= r_err;
        end
    end

    // Saturating count of stalled cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cycles <= 16'h0000;
        end else if (w_stall && (r_stall_cycles != 16'hFFFF)) begin
            r_stall_cycles <= r_stall_cycles + 16'h0001;
        end else begin
            r_stall_cycles <= r_stall_cycles;
        end
    end

    assign bus.stall        = w_stall;
    assign bus.bubble       = w_stall;
    assign bus.stall_cycles = r_stall_cycles;
    assign bus.err          = r_err;

endmodule
